// File: rtl/tlc_pkg.sv
// Shared types and default timing for the intersection phase scheduler.
package tlc_pkg;

    // Phase encoding; the numeric values are visible on the phase output.
    typedef enum logic [2:0] {
        PH_ALL_RED   = 3'd0,
        PH_NS_GREEN  = 3'd1,
        PH_NS_YELLOW = 3'd2,
        PH_EW_GREEN  = 3'd3,
        PH_EW_YELLOW = 3'd4,
        PH_WALK      = 3'd5
    } phase_e;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_e;

    localparam int unsigned DEF_MIN_GREEN    = 8;
    localparam int unsigned DEF_MAX_GREEN    = 20;
    localparam int unsigned DEF_YELLOW_TIME  = 3;
    localparam int unsigned DEF_ALL_RED_TIME = 2;
    localparam int unsigned DEF_WALK_TIME    = 6;

    // Green phase of the direction opposite the one served last.
    function automatic phase_e next_green(dir_e last_dir);
        return (last_dir == DIR_NS) ? PH_EW_GREEN : PH_NS_GREEN;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit saturating cycles-in-phase counter with synchronous clear.
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear on phase entry, otherwise count up and hold at 255.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-way intersection controller with strict NS/EW alternation and a
// pedestrian walk phase inserted after all-red when a request is latched.
module intersection_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int unsigned MIN_GREEN    = DEF_MIN_GREEN,
    parameter int unsigned MAX_GREEN    = DEF_MAX_GREEN,
    parameter int unsigned YELLOW_TIME  = DEF_YELLOW_TIME,
    parameter int unsigned ALL_RED_TIME = DEF_ALL_RED_TIME,
    parameter int unsigned WALK_TIME    = DEF_WALK_TIME
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase,
    output logic [7:0] phase_cnt
);

    // A phase of duration D exits on the edge where the count equals D-1.
    localparam logic [7:0] MIN_LAST  = 8'(MIN_GREEN - 1);
    localparam logic [7:0] MAX_LAST  = 8'(MAX_GREEN - 1);
    localparam logic [7:0] YEL_LAST  = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] AR_LAST   = 8'(ALL_RED_TIME - 1);
    localparam logic [7:0] WALK_LAST = 8'(WALK_TIME - 1);

    phase_e     phase_q, phase_d;
    dir_e       last_dir_q, last_dir_d;
    logic       ped_q, ped_d;
    logic       phase_change;
    logic [7:0] cnt;

    phase_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (phase_change),
        .cnt_o (cnt)
    );

    // Next-phase selection from the current phase, elapsed count and demand.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_ALL_RED: begin
                if (cnt == AR_LAST) begin
                    phase_d = ped_q ? PH_WALK : next_green(last_dir_q);
                end
            end
            PH_NS_GREEN: begin
                if ((cnt >= MIN_LAST) && (ew_req || ped_q) &&
                    (!ns_req || (cnt >= MAX_LAST))) begin
                    phase_d = PH_NS_YELLOW;
                end
            end
            PH_EW_GREEN: begin
                if ((cnt >= MIN_LAST) && (ns_req || ped_q) &&
                    (!ew_req || (cnt >= MAX_LAST))) begin
                    phase_d = PH_EW_YELLOW;
                end
            end
            PH_NS_YELLOW, PH_EW_YELLOW: begin
                if (cnt == YEL_LAST) begin
                    phase_d = PH_ALL_RED;
                end
            end
            PH_WALK: begin
                if (cnt == WALK_LAST) begin
                    phase_d = next_green(last_dir_q);
                end
            end
            default: phase_d = PH_ALL_RED;
        endcase
    end

    // Phase-entry bookkeeping: counter clear, last served direction, ped latch.
    always_comb begin
        phase_change = (phase_d != phase_q);
        last_dir_d   = last_dir_q;
        if (phase_change && (phase_d == PH_NS_GREEN)) begin
            last_dir_d = DIR_NS;
        end else if (phase_change && (phase_d == PH_EW_GREEN)) begin
            last_dir_d = DIR_EW;
        end
        ped_d = ped_q;
        if (ped_req && (phase_q != PH_WALK)) begin
            ped_d = 1'b1;
        end
        // Entering walk serves the request; this overrides a same-edge set.
        if (phase_change && (phase_d == PH_WALK)) begin
            ped_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= PH_ALL_RED;
            last_dir_q <= DIR_EW;
            ped_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            last_dir_q <= last_dir_d;
            ped_q      <= ped_d;
        end
    end

    // Moore lamp decode: inactive direction shows red only.
    always_comb begin
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        walk      = 1'b0;
        case (phase_q)
            PH_NS_GREEN:  begin ns_red = 1'b0; ns_green  = 1'b1; end
            PH_NS_YELLOW: begin ns_red = 1'b0; ns_yellow = 1'b1; end
            PH_EW_GREEN:  begin ew_red = 1'b0; ew_green  = 1'b1; end
            PH_EW_YELLOW: begin ew_red = 1'b0; ew_yellow = 1'b1; end
            PH_WALK:      walk = 1'b1;
            default:      ;
        endcase
    end

    assign ped_pending = ped_q;
    assign phase       = phase_q;
    assign phase_cnt   = cnt;

endmodule
